// File: rtl/dmem_resp_if.sv
// Execute->mem request bus and memwb writeback bus for the data-memory responder.
// master = execute (initiator), slave = dmem_resp.
interface dmem_resp_if;
  logic [15:0] mem_addr_ixmem_p1;
  logic [15:0] mem_data_in_ixmem_p1;
  logic        ldst_valid_ixmem_p1;
  logic [1:0]  store_valid_ixmem_p1;
  logic [15:0] dest_reg_value_ixmem_p1;
  logic [2:0]  dest_reg_index_ixmem_p1;
  logic        dest_reg_write_valid_ixmem_p1;
  logic [15:0] dest_reg_value_memwb_p1;
  logic [2:0]  dest_reg_index_memwb_p1;
  logic        dest_reg_write_valid_memwb_p1;
  logic        mem_stall_p1;
  logic        mem_err_p1;

  modport master (
    output mem_addr_ixmem_p1, mem_data_in_ixmem_p1, ldst_valid_ixmem_p1,
           store_valid_ixmem_p1, dest_reg_value_ixmem_p1,
           dest_reg_index_ixmem_p1, dest_reg_write_valid_ixmem_p1,
    input  dest_reg_value_memwb_p1, dest_reg_index_memwb_p1,
           dest_reg_write_valid_memwb_p1, mem_stall_p1, mem_err_p1
  );

  modport slave (
    input  mem_addr_ixmem_p1, mem_data_in_ixmem_p1, ldst_valid_ixmem_p1,
           store_valid_ixmem_p1, dest_reg_value_ixmem_p1,
           dest_reg_index_ixmem_p1, dest_reg_write_valid_ixmem_p1,
    output dest_reg_value_memwb_p1, dest_reg_index_memwb_p1,
           dest_reg_write_valid_memwb_p1, mem_stall_p1, mem_err_p1
  );
endinterface

// File: rtl/dmem_resp.sv
// Data-memory responder: DEPTH x 16b array, RD_LAT-cycle load/store, ALU passthrough to memwb.
// Stalls upstream combinationally while an access is outstanding; completion edge commits and writes back.
module dmem_resp #(
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input logic       clk,
  input logic       rst,
  dmem_resp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state;
  logic [1:0]     cnt;
  logic [15:0]    mem [DEPTH];
  logic [15:0]    wb_val;
  logic [2:0]     wb_idx;
  logic           wb_wv;
  logic           err;

  logic [AW-1:0]  idx;
  logic           lv;
  logic [1:0]     sv;
  logic           bad;
  logic           done;
  logic           is_wr;
  logic           wr_en;

  assign lv    = bus.ldst_valid_ixmem_p1;
  assign sv    = bus.store_valid_ixmem_p1;
  assign idx   = bus.mem_addr_ixmem_p1[AW:1];
  assign bad   = bus.mem_addr_ixmem_p1[0] | (sv == 2'b11);
  assign is_wr = (sv == 2'b01) | (sv == 2'b10);
  assign done  = ((state == IDLE) && lv && (RD_LAT == 1)) ||
                 ((state == BUSY) && (cnt == 2'd1));
  assign wr_en = done && is_wr && !bad && !rst;

  // rst term lets stall drop immediately even while upstream still holds the request
  assign bus.mem_stall_p1 = !rst &&
                            (((state == IDLE) && lv && (RD_LAT > 1)) ||
                             ((state == BUSY) && (cnt > 2'd1)));

  assign bus.dest_reg_value_memwb_p1       = wb_val;
  assign bus.dest_reg_index_memwb_p1       = wb_idx;
  assign bus.dest_reg_write_valid_memwb_p1 = wb_wv;
  assign bus.mem_err_p1                    = err;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= bus.mem_data_in_ixmem_p1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      wb_val <= 16'd0;
      wb_idx <= 3'd0;
      wb_wv  <= 1'b0;
      err    <= 1'b0;
    end else if (done) begin
      state <= IDLE;
      cnt   <= 2'd0;
      if (bad) begin
        wb_wv <= 1'b0;
        err   <= 1'b1;
      end else begin
        case (sv)
          2'b00: begin
            wb_val <= mem[idx];
            wb_idx <= bus.dest_reg_index_ixmem_p1;
            wb_wv  <= 1'b1;
          end
          2'b10: begin
            wb_val <= bus.dest_reg_value_ixmem_p1;
            wb_idx <= bus.dest_reg_index_ixmem_p1;
            wb_wv  <= bus.dest_reg_write_valid_ixmem_p1;
          end
          default: wb_wv <= 1'b0;
        endcase
      end
    end else if (state == IDLE) begin
      if (!lv) begin
        wb_val <= bus.dest_reg_value_ixmem_p1;
        wb_idx <= bus.dest_reg_index_ixmem_p1;
        wb_wv  <= bus.dest_reg_write_valid_ixmem_p1;
      end else begin
        state <= BUSY;
        cnt   <= 2'(RD_LAT - 1);
        wb_wv <= 1'b0;
      end
    end else begin
      cnt   <= cnt - 2'd1;
      wb_wv <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: three instances at RD_LAT 1, 3 and 4 sharing one clock and reset.
module tb_dmem_resp;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic        lv;
    logic [1:0]  sv;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] dv;
    logic [2:0]  di;
    logic        dw;
  } req_t;

  req_t q1, q3, q4;

  dmem_resp_if i1 ();
  dmem_resp_if i3 ();
  dmem_resp_if i4 ();

  dmem_resp #(.DEPTH(256), .RD_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
  dmem_resp #(.DEPTH(256), .RD_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(i3));
  dmem_resp #(.DEPTH(256), .RD_LAT(4)) u4 (.clk(clk), .rst(rst), .bus(i4));

  assign i1.ldst_valid_ixmem_p1           = q1.lv;
  assign i1.store_valid_ixmem_p1          = q1.sv;
  assign i1.mem_addr_ixmem_p1             = q1.addr;
  assign i1.mem_data_in_ixmem_p1          = q1.data;
  assign i1.dest_reg_value_ixmem_p1       = q1.dv;
  assign i1.dest_reg_index_ixmem_p1       = q1.di;
  assign i1.dest_reg_write_valid_ixmem_p1 = q1.dw;
  assign i3.ldst_valid_ixmem_p1           = q3.lv;
  assign i3.store_valid_ixmem_p1          = q3.sv;
  assign i3.mem_addr_ixmem_p1             = q3.addr;
  assign i3.mem_data_in_ixmem_p1          = q3.data;
  assign i3.dest_reg_value_ixmem_p1       = q3.dv;
  assign i3.dest_reg_index_ixmem_p1       = q3.di;
  assign i3.dest_reg_write_valid_ixmem_p1 = q3.dw;
  assign i4.ldst_valid_ixmem_p1           = q4.lv;
  assign i4.store_valid_ixmem_p1          = q4.sv;
  assign i4.mem_addr_ixmem_p1             = q4.addr;
  assign i4.mem_data_in_ixmem_p1          = q4.data;
  assign i4.dest_reg_value_ixmem_p1       = q4.dv;
  assign i4.dest_reg_index_ixmem_p1       = q4.di;
  assign i4.dest_reg_write_valid_ixmem_p1 = q4.dw;

  always #5 clk = ~clk;

  function automatic req_t mk(input logic lv, input logic [1:0] sv, input logic [15:0] addr,
                              input logic [15:0] data, input logic [15:0] dv,
                              input logic [2:0] di, input logic dw);
    mk = '{lv: lv, sv: sv, addr: addr, data: data, dv: dv, di: di, dw: dw};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    q1 = '0;
    q3 = '0;
    q4 = '0;
    #2;
    chk("rst_wb1",    {i1.dest_reg_value_memwb_p1, i1.dest_reg_index_memwb_p1, i1.dest_reg_write_valid_memwb_p1}, 32'h0);
    chk("rst_stall1", i1.mem_stall_p1, 0);
    chk("rst_err1",   i1.mem_err_p1, 0);
    chk("rst_wb3",    {i3.dest_reg_value_memwb_p1, i3.dest_reg_index_memwb_p1, i3.dest_reg_write_valid_memwb_p1}, 32'h0);
    chk("rst_stall4", i4.mem_stall_p1, 0);
    tick();
    rst = 1'b0;

    // RD_LAT=1: store then load same word, no stall
    q1 = mk(1, 2'b01, 16'h0010, 16'hBEEF, 16'h0, 3'd0, 1'b0);
    #1 chk("l1_st_stall", i1.mem_stall_p1, 0);
    tick();
    q1 = mk(1, 2'b00, 16'h0010, 16'h0, 16'h0, 3'd3, 1'b1);
    #1 chk("l1_ld_stall", i1.mem_stall_p1, 0);
    chk("l1_st_nowb", i1.dest_reg_write_valid_memwb_p1, 0);
    tick();
    chk("l1_ld_wb", {i1.dest_reg_value_memwb_p1, i1.dest_reg_index_memwb_p1, i1.dest_reg_write_valid_memwb_p1}, {16'hBEEF, 3'd3, 1'b1});
    q1 = mk(0, 2'b00, 16'h0, 16'h0, 16'h7777, 3'd6, 1'b1);
    tick();
    chk("l1_pass", {i1.dest_reg_value_memwb_p1, i1.dest_reg_index_memwb_p1, i1.dest_reg_write_valid_memwb_p1}, {16'h7777, 3'd6, 1'b1});
    q1 = mk(1, 2'b10, 16'h0020, 16'h00AA, 16'h0020, 3'd5, 1'b1);
    tick();
    chk("l1_stu_wb", {i1.dest_reg_value_memwb_p1, i1.dest_reg_index_memwb_p1, i1.dest_reg_write_valid_memwb_p1}, {16'h0020, 3'd5, 1'b1});
    q1 = mk(1, 2'b00, 16'h0020, 16'h0, 16'h0, 3'd1, 1'b1);
    tick();
    chk("l1_stu_mem", {i1.dest_reg_value_memwb_p1, i1.dest_reg_index_memwb_p1, i1.dest_reg_write_valid_memwb_p1}, {16'h00AA, 3'd1, 1'b1});

    // 0x0202 and 0x0002 alias to word 1 with DEPTH=256
    q1 = mk(1, 2'b01, 16'h0202, 16'hCAFE, 16'h0, 3'd0, 1'b0);
    tick();
    q1 = mk(1, 2'b00, 16'h0002, 16'h0, 16'h0, 3'd4, 1'b1);
    tick();
    chk("l1_wrap", {i1.dest_reg_value_memwb_p1, i1.dest_reg_index_memwb_p1, i1.dest_reg_write_valid_memwb_p1}, {16'hCAFE, 3'd4, 1'b1});

    q1 = mk(1, 2'b00, 16'h0011, 16'h0, 16'h0, 3'd7, 1'b1);
    #1 chk("l1_err_pre", i1.mem_err_p1, 0);
    tick();
    chk("l1_err_set", i1.mem_err_p1, 1);
    chk("l1_err_nowb", i1.dest_reg_write_valid_memwb_p1, 0);
    q1 = mk(1, 2'b11, 16'h0010, 16'h9999, 16'h0, 3'd0, 1'b1);
    tick();
    q1 = mk(1, 2'b00, 16'h0010, 16'h0, 16'h0, 3'd3, 1'b1);
    tick();
    chk("l1_illegal_nowr", {i1.dest_reg_value_memwb_p1, i1.dest_reg_index_memwb_p1, i1.dest_reg_write_valid_memwb_p1}, {16'hBEEF, 3'd3, 1'b1});
    q1 = '0;
    repeat (3) tick();
    chk("l1_err_sticky", i1.mem_err_p1, 1);

    // RD_LAT=3: preload then load with 2 stall cycles
    q3 = mk(1, 2'b01, 16'h0004, 16'h1234, 16'h0, 3'd0, 1'b0);
    repeat (3) tick();
    q3 = mk(1, 2'b00, 16'h0004, 16'h0, 16'h0, 3'd2, 1'b1);
    #1 chk("l3_stall_a", i3.mem_stall_p1, 1);
    chk("l3_bub_a", i3.dest_reg_write_valid_memwb_p1, 0);
    tick();
    chk("l3_stall_b", i3.mem_stall_p1, 1);
    chk("l3_bub_b", i3.dest_reg_write_valid_memwb_p1, 0);
    tick();
    chk("l3_stall_c", i3.mem_stall_p1, 0);
    chk("l3_bub_c", i3.dest_reg_write_valid_memwb_p1, 0);
    tick();
    chk("l3_ld_wb", {i3.dest_reg_value_memwb_p1, i3.dest_reg_index_memwb_p1, i3.dest_reg_write_valid_memwb_p1}, {16'h1234, 3'd2, 1'b1});
    q3 = '0;

    // RD_LAT=4: reset during BUSY drops the pending store
    q4 = mk(1, 2'b01, 16'h0002, 16'h1111, 16'h0, 3'd0, 1'b0);
    repeat (4) tick();
    q4 = mk(1, 2'b01, 16'h0002, 16'h5555, 16'h0, 3'd0, 1'b0);
    #1 chk("l4_stall_a", i4.mem_stall_p1, 1);
    tick();
    tick();
    chk("l4_stall_b", i4.mem_stall_p1, 1);
    rst = 1'b1;
    #1 chk("l4_rst_stall", i4.mem_stall_p1, 0);
    chk("l4_rst_wb", {i4.dest_reg_value_memwb_p1, i4.dest_reg_index_memwb_p1, i4.dest_reg_write_valid_memwb_p1}, 32'h0);
    chk("l1_err_clr", i1.mem_err_p1, 0);
    q4 = '0;
    tick();
    rst = 1'b0;
    tick();
    q4 = mk(1, 2'b00, 16'h0002, 16'h0, 16'h0, 3'd1, 1'b1);
    repeat (3) tick();
    chk("l4_stall_end", i4.mem_stall_p1, 0);
    tick();
    chk("l4_old_val", {i4.dest_reg_value_memwb_p1, i4.dest_reg_index_memwb_p1, i4.dest_reg_write_valid_memwb_p1}, {16'h1111, 3'd1, 1'b1});
    q4 = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
